// File: rtl/usb_cfg_rx_if.sv
// usb_cfg_rx_if: groups the FX2 config-endpoint bus and the decoder-side bus of usb_cfg_rx.
//   FX2 side     : cfg_req, ep_empty_n, fifo_data (to receiver); fifoadr, sloe_n, slrd_n (from receiver)
//   decoder side : usb_en, usb_wr, usb_data (from receiver)
//   status       : busy, frame_done, frame_err (from receiver)
// The receiver connects through the slave modport; the environment uses master.
interface usb_cfg_rx_if;
   logic        cfg_req;
   logic        ep_empty_n;
   logic [15:0] fifo_data;
   logic [1:0]  fifoadr;
   logic        sloe_n;
   logic        slrd_n;
   logic        usb_en;
   logic        usb_wr;
   logic [15:0] usb_data;
   logic        busy;
   logic        frame_done;
   logic        frame_err;

   modport slave (
      input  cfg_req, ep_empty_n, fifo_data,
      output fifoadr, sloe_n, slrd_n, usb_en, usb_wr, usb_data, busy, frame_done, frame_err
   );

   modport master (
      output cfg_req, ep_empty_n, fifo_data,
      input  fifoadr, sloe_n, slrd_n, usb_en, usb_wr, usb_data, busy, frame_done, frame_err
   );
endinterface

// File: rtl/usb_cfg_rx.sv
// usb_cfg_rx: reads 16-bit config words from the FX2 slave FIFO, buffers one complete frame
// (0xF5A5 ... 0xFA5A) and replays it to the config decoder as a gap-free burst.
// Ports:
//   usb_clk  clock
//   usb_rst  asynchronous, active-high reset
//   bus      usb_cfg_rx_if.slave: FX2 read interface, decoder word stream, status flags
module usb_cfg_rx #(
   parameter int unsigned DEPTH_LOG2 = 6,
   parameter logic [1:0]  EP_ADDR    = 2'b00,
   parameter logic [15:0] TIMEOUT    = 16'hFFFF
) (
   input  logic        usb_clk,
   input  logic        usb_rst,
   usb_cfg_rx_if.slave bus
);
   localparam int unsigned PTR_W = DEPTH_LOG2 + 1;
   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam logic [PTR_W-1:0] FULL = PTR_W'(DEPTH);
   localparam logic [15:0] HDR = 16'hF5A5;
   localparam logic [15:0] TRL = 16'hFA5A;

   typedef enum logic [2:0] {IDLE, HUNT, COLLECT, REPLAY, DONE} state_t;

   state_t            state, state_nxt;
   logic [PTR_W-1:0]  wr_ptr, wr_ptr_nxt;
   logic [PTR_W-1:0]  rd_ptr, rd_ptr_nxt;
   logic [PTR_W-1:0]  len, len_nxt;
   logic [15:0]       idle_cnt, idle_cnt_nxt;
   logic              slrd_n, slrd_n_nxt;
   logic              sloe_n, sloe_n_nxt;
   logic              usb_en, usb_en_nxt;
   logic              usb_wr, usb_wr_nxt;
   logic [15:0]       usb_data, usb_data_nxt;
   logic              busy, busy_nxt;
   logic              frame_done, frame_done_nxt;
   logic              frame_err, frame_err_nxt;
   logic              in_rx;

   logic [15:0]           mem [DEPTH];
   logic                  mem_we;
   logic [DEPTH_LOG2-1:0] mem_waddr;
   logic [15:0]           mem_wdata;

   // Frame buffer; contents are don't-care after reset, so no reset here.
   always_ff @(posedge usb_clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   // State and output registers.
   always_ff @(posedge usb_clk or posedge usb_rst) begin
      if (usb_rst) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         len        <= '0;
         idle_cnt   <= '0;
         slrd_n     <= 1'b1;
         sloe_n     <= 1'b1;
         usb_en     <= 1'b0;
         usb_wr     <= 1'b0;
         usb_data   <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         state      <= state_nxt;
         wr_ptr     <= wr_ptr_nxt;
         rd_ptr     <= rd_ptr_nxt;
         len        <= len_nxt;
         idle_cnt   <= idle_cnt_nxt;
         slrd_n     <= slrd_n_nxt;
         sloe_n     <= sloe_n_nxt;
         usb_en     <= usb_en_nxt;
         usb_wr     <= usb_wr_nxt;
         usb_data   <= usb_data_nxt;
         busy       <= busy_nxt;
         frame_done <= frame_done_nxt;
         frame_err  <= frame_err_nxt;
      end
   end

   // Next state, buffer write and next output values.
   // A word is on fifo_data exactly in the cycle where the registered slrd_n is low.
   always_comb begin
      state_nxt      = state;
      wr_ptr_nxt     = wr_ptr;
      rd_ptr_nxt     = rd_ptr;
      len_nxt        = len;
      idle_cnt_nxt   = idle_cnt;
      usb_en_nxt     = 1'b0;
      usb_wr_nxt     = 1'b0;
      usb_data_nxt   = usb_data;
      frame_done_nxt = 1'b0;
      frame_err_nxt  = frame_err;
      mem_we         = 1'b0;
      mem_waddr      = wr_ptr[DEPTH_LOG2-1:0];
      mem_wdata      = bus.fifo_data;

      unique case (state)
         IDLE: begin
            if (bus.cfg_req) state_nxt = HUNT;
         end
         HUNT: begin
            if (!bus.cfg_req) begin
               state_nxt = IDLE;
            end else if (!slrd_n && bus.fifo_data == HDR) begin
               mem_we        = 1'b1;
               mem_waddr     = '0;
               wr_ptr_nxt    = PTR_W'(1);
               idle_cnt_nxt  = '0;
               frame_err_nxt = 1'b0;
               state_nxt     = COLLECT;
            end
         end
         COLLECT: begin
            if (!bus.cfg_req) begin
               state_nxt = IDLE;
            end else if (!slrd_n) begin
               idle_cnt_nxt = '0;
               if (wr_ptr == FULL) begin
                  frame_err_nxt = 1'b1;
                  state_nxt     = HUNT;
               end else begin
                  mem_we     = 1'b1;
                  wr_ptr_nxt = wr_ptr + PTR_W'(1);
                  if (bus.fifo_data == TRL) begin
                     len_nxt    = wr_ptr + PTR_W'(1);
                     rd_ptr_nxt = '0;
                     state_nxt  = REPLAY;
                  end
               end
            end else if (idle_cnt == TIMEOUT - 16'd1) begin
               frame_err_nxt = 1'b1;
               state_nxt     = HUNT;
            end else begin
               idle_cnt_nxt = idle_cnt + 16'd1;
            end
         end
         REPLAY: begin
            usb_en_nxt   = 1'b1;
            usb_wr_nxt   = 1'b1;
            usb_data_nxt = mem[rd_ptr[DEPTH_LOG2-1:0]];
            rd_ptr_nxt   = rd_ptr + PTR_W'(1);
            if (rd_ptr == len - PTR_W'(1)) state_nxt = DONE;
         end
         DONE: begin
            usb_wr_nxt     = 1'b1;
            usb_data_nxt   = TRL;
            frame_done_nxt = 1'b1;
            state_nxt      = bus.cfg_req ? HUNT : IDLE;
         end
         default: state_nxt = IDLE;
      endcase

      // Strobe only after a high cycle: one word per two cycles hides the FX2 flag latency.
      in_rx      = (state_nxt == HUNT) || (state_nxt == COLLECT);
      sloe_n_nxt = !in_rx;
      slrd_n_nxt = !(((state == HUNT) || (state == COLLECT)) && in_rx && bus.ep_empty_n && slrd_n);
      busy_nxt   = (state_nxt != IDLE);
   end

   assign bus.fifoadr    = EP_ADDR;
   assign bus.slrd_n     = slrd_n;
   assign bus.sloe_n     = sloe_n;
   assign bus.usb_en     = usb_en;
   assign bus.usb_wr     = usb_wr;
   assign bus.usb_data   = usb_data;
   assign bus.busy       = busy;
   assign bus.frame_done = frame_done;
   assign bus.frame_err  = frame_err;
endmodule
